// File: rtl/sram_controller.sv
// Splits 32-bit pipeline loads/stores into two 16-bit SRAM half-accesses.
// Each half lasts WAIT_CYCLES clocks. ready is low while the pipeline must freeze.
module sram_controller #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    input  logic [15:0] SRAM_DQ_in,
    output logic [15:0] SRAM_DQ_out,
    output logic        SRAM_DQ_oe,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_LO = 3'd1;
    localparam logic [2:0] S_RD_HI = 3'd2;
    localparam logic [2:0] S_WR_LO = 3'd3;
    localparam logic [2:0] S_WR_HI = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] off_s;
    logic        last_s;
    logic        unused_off_s;

    // SRAM space starts at byte 1024; bits [17:2] select the 32-bit word.
    assign off_s        = addr_q - 32'd1024;
    assign unused_off_s = ^{off_s[31:18], off_s[1:0]};
    assign last_s       = (cnt_q == CNT_LAST);

    // Next-state, wait counter, request latching and read-data capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (wr_en) begin
                    state_d = S_WR_LO;
                    cnt_d   = 4'd0;
                    addr_d  = address;
                    wdata_d = write_data;
                end else if (rd_en) begin
                    state_d = S_RD_LO;
                    cnt_d   = 4'd0;
                    addr_d  = address;
                    wdata_d = write_data;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_LO: begin
                if (last_s) begin
                    state_d        = S_RD_HI;
                    cnt_d          = 4'd0;
                    rdata_d[15:0]  = SRAM_DQ_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RD_HI: begin
                if (last_s) begin
                    state_d        = S_DONE;
                    cnt_d          = 4'd0;
                    rdata_d[31:16] = SRAM_DQ_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_LO: begin
                if (last_s) begin
                    state_d = S_WR_HI;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WR_HI: begin
                if (last_s) begin
                    state_d = S_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                // A request still held here belongs to the access just finished.
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // SRAM strobes, address, write data and pipeline ready decoded from state
    always_comb begin
        ready       = 1'b0;
        SRAM_ADDR   = 18'd0;
        SRAM_DQ_out = 16'd0;
        SRAM_DQ_oe  = 1'b0;
        SRAM_WE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        case (state_q)
            S_IDLE: begin
                ready = ~(wr_en | rd_en);
            end
            S_RD_LO: begin
                SRAM_ADDR = {off_s[17:2], 1'b0};
                SRAM_OE_N = 1'b0;
            end
            S_RD_HI: begin
                SRAM_ADDR = {off_s[17:2], 1'b1};
                SRAM_OE_N = 1'b0;
            end
            S_WR_LO: begin
                SRAM_ADDR   = {off_s[17:2], 1'b0};
                SRAM_DQ_out = wdata_q[15:0];
                SRAM_DQ_oe  = 1'b1;
                SRAM_WE_N   = 1'b0;
            end
            S_WR_HI: begin
                SRAM_ADDR   = {off_s[17:2], 1'b1};
                SRAM_DQ_out = wdata_q[31:16];
                SRAM_DQ_oe  = 1'b1;
                SRAM_WE_N   = 1'b0;
            end
            S_DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign read_data = rdata_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized self-checking bench: two controllers (WAIT_CYCLES 2 and 1) share one
// behavioural SRAM and are checked against an address/data reference model.
module tb_sram_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_en, rd_en, sel_w1;
    logic [31:0] address, write_data;
    logic [15:0] dq_in;

    logic [31:0] rdata_a, rdata_b;
    logic        ready_a, ready_b, dq_oe_a, dq_oe_b, we_n_a, we_n_b, oe_n_a, oe_n_b;
    logic        ce_a, ce_b, ub_a, ub_b, lb_a, lb_b;
    logic [17:0] addr_a, addr_b;
    logic [15:0] dq_out_a, dq_out_b;

    // Muxed view of whichever controller is selected
    logic [31:0] m_rdata;
    logic        m_ready, m_dq_oe, m_we_n, m_oe_n;
    logic [17:0] m_addr;
    logic [15:0] m_dq_out;
    assign m_rdata  = sel_w1 ? rdata_b  : rdata_a;
    assign m_ready  = sel_w1 ? ready_b  : ready_a;
    assign m_dq_oe  = sel_w1 ? dq_oe_b  : dq_oe_a;
    assign m_we_n   = sel_w1 ? we_n_b   : we_n_a;
    assign m_oe_n   = sel_w1 ? oe_n_b   : oe_n_a;
    assign m_addr   = sel_w1 ? addr_b   : addr_a;
    assign m_dq_out = sel_w1 ? dq_out_b : dq_out_a;

    sram_controller #(.WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .wr_en(wr_en & ~sel_w1), .rd_en(rd_en & ~sel_w1),
        .address(address), .write_data(write_data), .read_data(rdata_a), .ready(ready_a),
        .SRAM_ADDR(addr_a), .SRAM_DQ_in(dq_in), .SRAM_DQ_out(dq_out_a), .SRAM_DQ_oe(dq_oe_a),
        .SRAM_WE_N(we_n_a), .SRAM_OE_N(oe_n_a), .SRAM_CE_N(ce_a), .SRAM_UB_N(ub_a),
        .SRAM_LB_N(lb_a)
    );

    sram_controller #(.WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst), .wr_en(wr_en & sel_w1), .rd_en(rd_en & sel_w1),
        .address(address), .write_data(write_data), .read_data(rdata_b), .ready(ready_b),
        .SRAM_ADDR(addr_b), .SRAM_DQ_in(dq_in), .SRAM_DQ_out(dq_out_b), .SRAM_DQ_oe(dq_oe_b),
        .SRAM_WE_N(we_n_b), .SRAM_OE_N(oe_n_b), .SRAM_CE_N(ce_b), .SRAM_UB_N(ub_b),
        .SRAM_LB_N(lb_b)
    );

    // Power-up contents of the SRAM; halfwords 0/1 hold the classic read pattern
    function automatic logic [15:0] init_val(input logic [17:0] a);
        case (a)
            18'd0:   init_val = 16'h1234;
            18'd1:   init_val = 16'hABCD;
            default: init_val = (a[15:0] * 16'h9E37) ^ 16'h5A5A ^ {14'd0, a[17:16]};
        endcase
    endfunction

    // Behavioural SRAM
    logic [15:0] sram_mem [0:262143];
    bit          written  [0:262143];
    always @(posedge clk) begin
        if (!m_we_n) begin
            sram_mem[m_addr] = m_dq_out;
            written[m_addr]  = 1'b1;
        end
    end
    assign dq_in = m_oe_n ? 16'h0000 : (written[m_addr] ? sram_mem[m_addr] : init_val(m_addr));

    function automatic logic [15:0] model_rd(input int a);
        model_rd = written[a] ? sram_mem[a] : init_val(18'(a));
    endfunction

    // Reference model: expected memory image and expected read_data
    logic [15:0] ref_mem [int];
    logic [31:0] exp_rdata;
    function automatic logic [15:0] ref_rd(input int a);
        ref_rd = ref_mem.exists(a) ? ref_mem[a] : init_val(18'(a));
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One complete access starting at a negedge with the controller idle
    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input bit drop);
        int          w, hw;
        bit          hi;
        logic [31:0] off;
        w   = sel_w1 ? 1 : 2;
        off = a - 32'd1024;
        hw  = int'(((off / 32'd4) % 32'd65536) * 32'd2);
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        #1;
        check_eq("req_ready", 32'(m_ready), 32'd0);
        check_eq("req_addr", 32'(m_addr), 32'd0);
        for (int i = 1; i <= 2 * w; i++) begin
            @(negedge clk);
            hi = (i > w);
            check_eq("busy_ready", 32'(m_ready), 32'd0);
            check_eq("busy_addr", 32'(m_addr), 32'(hw + (hi ? 1 : 0)));
            if (wr) begin
                check_eq("wr_we_n", 32'(m_we_n), 32'd0);
                check_eq("wr_oe", 32'(m_dq_oe), 32'd1);
                check_eq("wr_dq", 32'(m_dq_out), hi ? 32'(d[31:16]) : 32'(d[15:0]));
            end else begin
                check_eq("rd_oe_n", 32'(m_oe_n), 32'd0);
                check_eq("rd_we_n", 32'(m_we_n), 32'd1);
                check_eq("rd_oe", 32'(m_dq_oe), 32'd0);
            end
            if (drop && i == 1) begin
                wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
            end
        end
        @(negedge clk);
        if (wr) begin
            ref_mem[hw]     = d[15:0];
            ref_mem[hw + 1] = d[31:16];
            check_eq("mem_lo", 32'(model_rd(hw)), 32'(d[15:0]));
            check_eq("mem_hi", 32'(model_rd(hw + 1)), 32'(d[31:16]));
        end else begin
            exp_rdata = {ref_rd(hw + 1), ref_rd(hw)};
        end
        check_eq("done_ready", 32'(m_ready), 32'd1);
        check_eq("done_addr", 32'(m_addr), 32'd0);
        check_eq("done_we_n", 32'(m_we_n), 32'd1);
        check_eq("done_oe_n", 32'(m_oe_n), 32'd1);
        check_eq("read_data", m_rdata, exp_rdata);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check_eq("post_ready", 32'(m_ready), 32'd1);
        check_eq("post_we_n", 32'(m_we_n), 32'd1);
        check_eq("post_oe_n", 32'(m_oe_n), 32'd1);
    endtask

    initial begin
        int          kind;
        logic [31:0] a, d;
        bit          drop;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
        sel_w1 = 1'b0; exp_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(m_ready), 32'd1);
        check_eq("rst_rdata", m_rdata, 32'd0);
        check_eq("rst_addr", 32'(m_addr), 32'd0);
        check_eq("rst_strobes", {28'd0, m_we_n, m_oe_n, m_dq_oe, 1'b0}, 32'd12);
        check_eq("rst_dq_out", 32'(m_dq_out), 32'd0);
        check_eq("rst_ce_ub_lb", {29'd0, ce_a, ub_a, lb_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
        check_eq("read_1234", m_rdata, 32'hABCD1234);
        access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0);
        access(1'b1, 1'b1, 32'd1040, 32'h0BADF00D, 1'b0);
        access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);
        check_eq("read_back", m_rdata, 32'hDEADBEEF);

        // Reset during the high-half read
        rd_en = 1'b1; address = 32'd1040;
        repeat (3) @(negedge clk);
        check_eq("rsthi_addr", 32'(m_addr), 32'd9);
        rst = 1'b1; rd_en = 1'b0;
        @(negedge clk);
        check_eq("rsthi_ready", 32'(m_ready), 32'd1);
        check_eq("rsthi_rdata", m_rdata, 32'd0);
        check_eq("rsthi_oe_n", 32'(m_oe_n), 32'd1);
        check_eq("rsthi_addr0", 32'(m_addr), 32'd0);
        rst = 1'b0; exp_rdata = 32'd0;
        @(negedge clk);

        for (int pass = 0; pass < 2; pass++) begin
            sel_w1 = (pass == 1);
            @(negedge clk);
            if (pass == 1) begin
                access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
                access(1'b1, 1'b0, 32'd1028, 32'h13579BDF, 1'b0);
                access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0);
                check_eq("w1_read_back", m_rdata, 32'h13579BDF);
            end
            for (int n = 0; n < 30; n++) begin
                kind = $urandom_range(0, 3);
                a    = ($urandom_range(0, 7) == 0) ? $urandom
                       : 32'd1024 + 32'($urandom_range(0, 31)) * 32'd4 + 32'($urandom_range(0, 3));
                d    = $urandom;
                drop = ($urandom_range(0, 3) == 0);
                access(kind == 1 || kind == 2, kind != 1, a, d, drop);
                if ($urandom_range(0, 1) == 1) begin
                    @(negedge clk);
                    check_eq("gap_ready", 32'(m_ready), 32'd1);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: port clk is the only clock, and rst is sampled only on the rising edge of clk.
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set the number of clk cycles per 16-bit SRAM half-access (legal range 1..15).
REQ-003 Port list (name direction width meaning) SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  MEM-stage write request
- rd_en  in  1  MEM-stage read request
- address  in  32  byte address from EXE result
- write_data  in  32  store data (Val_Rm)
- read_data  out  32  load result
- ready  out  1  access complete; pipeline freeze = ~ready
- SRAM_ADDR  out  18  SRAM halfword address
- SRAM_DQ_in  in  16  SRAM data bus, read direction
- SRAM_DQ_out  out  16  SRAM data bus, write direction
- SRAM_DQ_oe  out  1  1 = controller drives the SRAM bus
- SRAM_WE_N  out  1  write enable, active-low
- SRAM_OE_N  out  1  output enable, active-low
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  chip/byte enables, tied 0

Function
REQ-004 The FSM SHALL have states IDLE, RD_LO, RD_HI, WR_LO, WR_HI and DONE.
REQ-005 In IDLE with wr_en=1, the FSM SHALL go to WR_LO. Otherwise, with rd_en=1, it SHALL go to RD_LO. With neither asserted it SHALL stay in IDLE. Write has priority when both are asserted.
REQ-006 On leaving IDLE, the block SHALL latch address and write_data into internal registers and clear the wait counter.
REQ-007 Address translation SHALL be off = address - 1024 (32-bit, wrap allowed), with SRAM_ADDR = {off[17:2], 1'b0} in *_LO states and {off[17:2], 1'b1} in *_HI states.
REQ-008 Each *_LO and *_HI state SHALL last exactly WAIT_CYCLES cycles, with the counter incrementing per cycle and the state advancing when counter == WAIT_CYCLES-1. The counter SHALL clear on each state change.
REQ-009 Transitions SHALL be RD_LO->RD_HI->DONE and WR_LO->WR_HI->DONE.
REQ-010 On the last RD_LO cycle, the block SHALL capture SRAM_DQ_in into read_data[15:0]. On the last RD_HI cycle, it SHALL capture SRAM_DQ_in into read_data[31:16].
REQ-011 read_data SHALL hold its value until the next read captures; writes SHALL NOT alter it.
REQ-012 In WR_LO and WR_HI, the outputs SHALL be SRAM_WE_N=0 and SRAM_DQ_oe=1. SRAM_DQ_out SHALL be latched write_data[15:0] in WR_LO and [31:16] in WR_HI.
REQ-013 In RD_LO and RD_HI, the outputs SHALL be SRAM_OE_N=0, SRAM_WE_N=1 and SRAM_DQ_oe=0.
REQ-014 In IDLE and DONE, the outputs SHALL be SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0, SRAM_DQ_out=0 and SRAM_ADDR=0.
REQ-015 ready SHALL be combinational:
- 1 in IDLE with wr_en=rd_en=0
- 0 in IDLE with any request
- 0 in all RD/WR states
- 1 in DONE
REQ-016 DONE SHALL last one cycle and SHALL go to IDLE unconditionally. The still-asserted request seen in DONE SHALL NOT start a new access.
REQ-017 Access latency SHALL be 2*WAIT_CYCLES+1 cycles of ready=0 counted from the request cycle. With WAIT_CYCLES=2, ready=0 for 5 cycles and ready=1 on the 6th (DONE).
REQ-018 Requesters SHALL hold wr_en, rd_en, address and write_data stable until ready=1. Input changes after acceptance SHALL be ignored, since the latched copies are used.
REQ-019 Dropping the request mid-access SHALL NOT abort the access: the sequence SHALL complete through DONE.

Reset
REQ-020 rst=1 at a clock edge SHALL force IDLE, counter=0, read_data=0 and the latched address/data=0, from any state including mid-access.
REQ-021 After reset, outputs SHALL match REQ-014, and ready SHALL follow REQ-015 for IDLE.
REQ-022 An access interrupted by reset SHALL be discarded. A write cut short may leave the SRAM halfword partially written.

Verification
REQ-023 Read: SRAM model holds 0x1234 at halfword 0 and 0xABCD at halfword 1; rd_en=1, address=1024 -> SRAM_ADDR=0 then 1, ready=0 for 5 cycles then 1, read_data=0xABCD1234.
REQ-024 Write: wr_en=1, address=1032, write_data=0xDEADBEEF -> SRAM_ADDR=4 with DQ_out=0xBEEF for 2 cycles, then SRAM_ADDR=5 with 0xDEAD for 2 cycles, WE_N=0 throughout, then ready=1.
REQ-025 Simultaneous wr_en=rd_en=1 -> the write sequence executes, and read_data keeps its prior value.
REQ-026 Request held through DONE -> exactly one access is performed, and the FSM is in IDLE on the cycle after DONE.
REQ-027 rst=1 during RD_HI -> next cycle state is IDLE, read_data=0, SRAM_OE_N=1, and ready=1 if no request is present.
REQ-028 WAIT_CYCLES=1, back-to-back read then write with one idle cycle between -> each access shows ready=0 for 3 cycles, with correct data both directions.
